// File: rtl/packet_display_scanner.sv
// Six-digit common-anode hex scanner: accepts one 24-bit packet, strobes its
// nibbles across the display for HOLD_FRAMES full frames, then takes the next.
module packet_display_scanner #(
  parameter int DIGIT_CYCLES  = 4,
  parameter int HOLD_FRAMES   = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        pkt_valid,
  input  logic [23:0] pkt_data,
  output logic        pkt_ready,
  output logic [6:0]  seg_n,
  output logic [5:0]  digit_en_n,
  output logic        frame_done
);

  localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(HOLD_FRAMES - 1);

  logic [0:0]    state_q, state_d;
  logic [23:0]   data_q, data_d;
  logic [2:0]    digit_q, digit_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [FW-1:0] frame_q, frame_d;

  logic scan, dwell_term, digit_last, frame_last, last_cycle;

  assign scan       = (state_q == S_SCAN);
  assign dwell_term = (dwell_q == DWELL_LAST);
  assign digit_last = (digit_q == 3'd5);
  assign frame_last = (frame_q == FRAME_LAST);
  assign last_cycle = scan & dwell_term & digit_last & frame_last;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    digit_d = digit_q;
    dwell_d = dwell_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          state_d = S_SCAN;
          data_d  = pkt_data;
          digit_d = 3'd0;
          dwell_d = '0;
          frame_d = '0;
        end
      end
      S_SCAN: begin
        if (dwell_term) begin
          dwell_d = '0;
          if (digit_last) begin
            digit_d = 3'd0;
            if (frame_last) begin
              state_d = S_IDLE;
              frame_d = '0;
            end else begin
              frame_d = frame_q + FW'(1);
            end
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      digit_q <= '0;
      dwell_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      digit_q <= digit_d;
      dwell_q <= dwell_d;
      frame_q <= frame_d;
    end
  end

  logic [3:0] nib;
  always_comb begin
    case (digit_q)
      3'd0:    nib = data_q[3:0];
      3'd1:    nib = data_q[7:4];
      3'd2:    nib = data_q[11:8];
      3'd3:    nib = data_q[15:12];
      3'd4:    nib = data_q[19:16];
      3'd5:    nib = data_q[23:20];
      default: nib = 4'h0;
    endcase
  end

  // zero_above[i]: nibbles i..5 are all zero; digit 0 is never blanked
  logic [7:0] zero_above;
  always_comb begin
    zero_above    = 8'h00;
    zero_above[5] = (data_q[23:20] == 4'h0);
    for (int i = 4; i >= 1; i--)
      zero_above[i] = zero_above[i+1] & (data_q[4*i +: 4] == 4'h0);
  end

  logic blank;
  assign blank = (BLANK_LEADING != 0) && zero_above[digit_q];

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign pkt_ready  = ~scan;
  assign digit_en_n = scan ? ~(6'b1 << digit_q) : 6'h3F;
  assign seg_n      = (!scan || blank) ? 7'h7F : hex7(nib);
  assign frame_done = last_cycle;

endmodule

// File: tb/tb_packet_display_scanner.sv
// Directed bench: three scanner instances (no blanking, blanking, minimum
// timing) sharing one clock and reset, checked against hand-written tables.
module tb_packet_display_scanner;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic clear_n = 1'b0;

  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [23:0] d0 = '0, d1 = '0, d2 = '0;
  logic r0, r1, r2, f0, f1, f2;
  logic [6:0] s0, s1, s2;
  logic [5:0] e0, e1, e2;

  packet_display_scanner #(.DIGIT_CYCLES(4), .HOLD_FRAMES(2), .BLANK_LEADING(0)) dut0 (
    .clock(clock), .clear_n(clear_n), .pkt_valid(v0), .pkt_data(d0),
    .pkt_ready(r0), .seg_n(s0), .digit_en_n(e0), .frame_done(f0));
  packet_display_scanner #(.DIGIT_CYCLES(4), .HOLD_FRAMES(2), .BLANK_LEADING(1)) dut1 (
    .clock(clock), .clear_n(clear_n), .pkt_valid(v1), .pkt_data(d1),
    .pkt_ready(r1), .seg_n(s1), .digit_en_n(e1), .frame_done(f1));
  packet_display_scanner #(.DIGIT_CYCLES(1), .HOLD_FRAMES(1), .BLANK_LEADING(1)) dut2 (
    .clock(clock), .clear_n(clear_n), .pkt_valid(v2), .pkt_data(d2),
    .pkt_ready(r2), .seg_n(s2), .digit_en_n(e2), .frame_done(f2));

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0] EN [6];
  logic [6:0] tab [6];
  logic [15:0] got, want;

  // advance one clock edge and settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({s0, e0, f0, r0, s1, e1, f1, r1} !== {7'h7F, 6'h3F, 1'b0, 1'b1, 7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state got %h/%h want 7f3f01/7f3f01", {s0, e0, f0, r0}, {s1, e1, f1, r1});
    end
    n_cmp++;
    if ({s2, e2, f2, r2} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state_min got %h want %h", {s2, e2, f2, r2}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
    clear_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({s0, e0, f0, r0} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL idle c=%0d got %h want %h", c, {s0, e0, f0, r0}, {7'h7F, 6'h3F, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_full_hex();
    tab = '{7'h00, 7'h79, 7'h40, 7'h0E, 7'h12, 7'h08};
    v0 = 1'b1; d0 = 24'hA5F018;
    tick();
    v0 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      got  = {s0, e0, f0, r0, 1'b0};
      want = {tab[((c-1)/4)%6], EN[((c-1)/4)%6], (c == 48), 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL full_hex c=%0d got %h want %h", c, got, want);
      end
      tick();
    end
    n_cmp++;
    if ({s0, e0, f0, r0} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL full_hex_release got %h want %h", {s0, e0, f0, r0}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
  endtask

  task automatic scan_dut1(input string name, input logic [23:0] pkt, input logic [6:0] t0,
                           input logic [6:0] t1, input logic [6:0] t2, input logic [6:0] t3,
                           input logic [6:0] t4, input logic [6:0] t5);
    tab = '{t0, t1, t2, t3, t4, t5};
    v1 = 1'b1; d1 = pkt;
    tick();
    v1 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      got  = {s1, e1, f1, r1, 1'b0};
      want = {tab[((c-1)/4)%6], EN[((c-1)/4)%6], (c == 48), 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s c=%0d got %h want %h", name, c, got, want);
      end
      tick();
    end
    n_cmp++;
    if ({s1, e1, f1, r1} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL %s_release got %h want %h", name, {s1, e1, f1, r1}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
  endtask

  task automatic test_blanking();
    scan_dut1("blank_123", 24'h000123, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    scan_dut1("blank_zero", 24'h000000, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    scan_dut1("blank_mid0", 24'h100000, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79);
  endtask

  task automatic test_back_to_back();
    v1 = 1'b1; d1 = 24'h111111;
    tick();
    d1 = 24'h222222;
    for (int c = 1; c <= 48; c++) begin
      got  = {s1, e1, f1, r1, 1'b0};
      want = {7'h79, EN[((c-1)/4)%6], (c == 48), 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b_first c=%0d got %h want %h", c, got, want);
      end
      tick();
    end
    n_cmp++;
    if ({s1, e1, f1, r1} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_gap got %h want %h", {s1, e1, f1, r1}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
    tick();
    v1 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      got  = {s1, e1, f1, r1, 1'b0};
      want = {7'h24, EN[((c-1)/4)%6], (c == 48), 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b_second c=%0d got %h want %h", c, got, want);
      end
      tick();
    end
    n_cmp++;
    if ({s1, e1, f1, r1} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_release got %h want %h", {s1, e1, f1, r1}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid_scan();
    v1 = 1'b1; d1 = 24'hFFFFFF;
    tick();
    v1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      got  = {s1, e1, f1, r1, 1'b0};
      want = {7'h0E, EN[((c-1)/4)%6], 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL mid_scan c=%0d got %h want %h", c, got, want);
      end
      if (c < 10) tick();
    end
    // reset and a new valid packet land on the same edge: reset must win
    clear_n = 1'b0; v1 = 1'b1; d1 = 24'h000001;
    tick();
    n_cmp++;
    if ({s1, e1, f1, r1} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset got %h want %h", {s1, e1, f1, r1}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
    clear_n = 1'b1;
    v1 = 1'b0;
    scan_dut1("after_reset", 24'h000001, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
  endtask

  task automatic test_min_params();
    tab = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    v2 = 1'b1; d2 = 24'h123456;
    tick();
    v2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      got  = {s2, e2, f2, r2, 1'b0};
      want = {tab[c-1], EN[c-1], (c == 6), 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL min_params c=%0d got %h want %h", c, got, want);
      end
      tick();
    end
    n_cmp++;
    if ({s2, e2, f2, r2} !== {7'h7F, 6'h3F, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL min_release got %h want %h", {s2, e2, f2, r2}, {7'h7F, 6'h3F, 1'b0, 1'b1});
    end
  endtask

  initial begin
    EN = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    test_reset();
    test_full_hex();
    test_blanking();
    test_back_to_back();
    test_reset_mid_scan();
    test_min_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_display_scanner.md
Name: packet_display_scanner

Overview:
Downstream consumer of the routing table's 24-bit packet output. Accepts one packet per valid/ready handshake, latches it, and time-multiplexes its six hex nibbles onto a six-digit common-anode seven-segment display. Holds each packet for a fixed number of full scan frames, then releases and accepts the next packet. Single clock domain.

Parameters:
DIGIT_CYCLES, 4, clock cycles each digit stays enabled (>=1)
HOLD_FRAMES, 2, complete 6-digit scans per accepted packet (>=1)
BLANK_LEADING, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  synchronous active-low reset
pkt_valid  input  1  upstream packet valid
pkt_data  input  24  packet from routing table output
pkt_ready  output  1  block can accept a packet this cycle
seg_n  output  7  active-low segments, bit0=a … bit6=g
digit_en_n  output  6  active-low digit enables, bit0 = rightmost digit = pkt_data[3:0]
frame_done  output  1  one-cycle pulse on final cycle of final hold frame

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clear_n sampled on rising edge of clock). On reset: state=IDLE; latched data, digit index, dwell counter and frame counter all 0. Outputs the cycle after: pkt_ready=1, seg_n=7'h7F, digit_en_n=6'h3F, frame_done=0. pkt_valid ignored while clear_n low.
- All outputs are pure combinational functions of registered state only. No input-to-output combinational path.
- States: IDLE, SCAN.
- IDLE:
  - pkt_ready=1; display dark (seg_n=7'h7F, digit_en_n=6'h3F).
  - On an edge with pkt_valid=1: latch pkt_data, set digit=0, dwell=0, frame=0, go to SCAN.
  - pkt_valid=0: stay in IDLE.
- SCAN:
  - pkt_ready=0. Upstream holds its data; nothing is dropped or overwritten.
  - digit_en_n = ~(6'b1 << digit).
  - seg_n = hex decode of latched nibble [4*digit+3 : 4*digit], or 7'h7F if that digit is blanked.
  - Dwell counts 0..DIGIT_CYCLES-1. At the terminal count, dwell returns to 0 and digit increments.
  - At digit 5 terminal, digit wraps to 0 and frame increments.
  - When frame=HOLD_FRAMES-1, digit=5 and dwell terminal: frame_done=1 for that cycle; next state is IDLE.
- Timing:
  - First lit digit appears in the cycle immediately after the acceptance edge.
  - SCAN lasts exactly 6*DIGIT_CYCLES*HOLD_FRAMES cycles (48 with defaults).
  - pkt_ready re-asserts the cycle after frame_done. Back-to-back packets are separated by exactly one dark IDLE cycle.
- Blanking (BLANK_LEADING=1): digit i (1..5) is blanked iff latched nibbles i..5 are all zero. Digit 0 always shows, so packet 0 displays a single "0".
- Hex decode (seg_n, active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset mid-SCAN: next cycle is IDLE with the display dark. The scan is aborted and frame_done is not pulsed.
- Reset asserted together with pkt_valid: reset wins and the packet is not accepted.
- HOLD_FRAMES=1 and DIGIT_CYCLES=1 must work; SCAN then lasts 6 cycles.

Test Plan:
1. Reset then idle: clear_n low 2 cycles, pkt_valid=0 → pkt_ready=1, seg_n=7F, digit_en_n=3F, frame_done never pulses.
2. Full hex scan, BLANK_LEADING=0: accept 24'hA5F018 → across digits 0..5 see seg_n 00,79,40,0E,12,08 with digit_en_n 3E,3D,3B,37,2F,1F. Each digit lasts 4 cycles; pattern repeats for 2 frames; frame_done pulses on cycle 48; pkt_ready=1 on cycle 49.
3. Leading-zero blanking: accept 24'h000123 → digits 0..2 show 30,24,79 and digits 3..5 show seg_n=7F with their enables still strobing. Packet 24'h000000 → only digit 0 shows 40.
4. Backpressure: hold pkt_valid=1 with 24'h111111 then 24'h222222 continuously → first packet accepted, pkt_ready=0 for 48 cycles, second packet accepted exactly one cycle after frame_done, no packet lost.
5. Reset mid-scan: accept 24'hFFFFFF, assert clear_n low at cycle 10 → next cycle display dark and pkt_ready=1, no frame_done pulse. A new packet 24'h000001 is then accepted and shows 79 on digit 0.
6. Minimum parameters (DIGIT_CYCLES=1, HOLD_FRAMES=1): accept 24'h123456 → 6 consecutive cycles show digits 0..5, frame_done on the 6th cycle, pkt_ready on the 7th.
